// File: rtl/alu_seq_pkg.sv
// Shared encodings for the ALU sequencer: op codes, FSM states, response flag bit positions.
package alu_seq_pkg;

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_MUL = 2'b10;
    localparam logic [1:0] OP_DIV = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    localparam int FLAG_ZERO   = 3;
    localparam int FLAG_CARRY  = 2;
    localparam int FLAG_SIGN   = 1;
    localparam int FLAG_PARITY = 0;

    function automatic logic is_div0(input logic [1:0] op, input logic [3:0] b);
        return (op == OP_DIV) && (b == 4'd0);
    endfunction

endpackage

// File: rtl/alu.sv
// Combinational 4-bit unsigned ALU driven by the sequencer; parity flags an even count of ones.
module alu
    import alu_seq_pkg::*;
(
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic [1:0] select,
    output logic [3:0] out,
    output logic       zero,
    output logic       carry,
    output logic       sign,
    output logic       parity
);

    logic [4:0] w_res;
    logic [7:0] w_prod;

    always_comb begin
        w_res  = 5'd0;
        w_prod = {4'd0, a} * {4'd0, b};
        case (select)
            OP_ADD:  w_res = {1'b0, a} + {1'b0, b};
            OP_SUB:  w_res = {1'b0, a} - {1'b0, b};   // bit 4 is the borrow
            OP_MUL:  w_res = {|w_prod[7:4], w_prod[3:0]};
            default: w_res = (b == 4'd0) ? 5'd0 : {1'b0, a / b};
        endcase
    end

    assign out    = w_res[3:0];
    assign carry  = w_res[4];
    assign zero   = (w_res[3:0] == 4'd0);
    assign sign   = w_res[3];
    assign parity = ~^w_res[3:0];

endmodule

// File: rtl/alu_seq_stats.sv
// Saturating 8-bit counters of completed responses and of responses carrying carry = 1.
module alu_seq_stats (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       i_hs,
    input  logic       i_carry,
    output logic [7:0] o_stat_ops,
    output logic [7:0] o_stat_carry
);

    logic [7:0] r_ops;
    logic [7:0] r_carry;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_ops   <= 8'd0;
            r_carry <= 8'd0;
        end else if (i_hs) begin
            if (r_ops != 8'hFF)
                r_ops <= r_ops + 8'd1;
            if (i_carry && (r_carry != 8'hFF))
                r_carry <= r_carry + 8'd1;
        end
    end

    assign o_stat_ops   = r_ops;
    assign o_stat_carry = r_carry;

endmodule

// File: rtl/alu_seq_ctrl.sv
// Sequential front-end for the 4-bit ALU: command handshake -> ALU operands -> captured response.
// Response statistics counters are built only when ALU_SEQ_STATS_EN is defined.
module alu_seq_ctrl
    import alu_seq_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [3:0] cmd_a,
    input  logic [3:0] cmd_b,
    input  logic [1:0] cmd_op,
    output logic [3:0] alu_a,
    output logic [3:0] alu_b,
    output logic [1:0] alu_select,
    input  logic [3:0] alu_out,
    input  logic       alu_zero,
    input  logic       alu_carry,
    input  logic       alu_sign,
    input  logic       alu_parity,
    output logic       rsp_valid,
    input  logic       rsp_ready,
    output logic [3:0] rsp_out,
    output logic [3:0] rsp_flags,
    output logic       rsp_div0,
    output logic [7:0] stat_ops,
    output logic [7:0] stat_carry
);

    state_t r_state;
    logic   r_div0;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state    <= ST_IDLE;
            r_div0     <= 1'b0;
            cmd_ready  <= 1'b1;
            alu_a      <= 4'd0;
            alu_b      <= 4'd0;
            alu_select <= 2'd0;
            rsp_valid  <= 1'b0;
            rsp_out    <= 4'd0;
            rsp_flags  <= 4'd0;
            rsp_div0   <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (cmd_valid) begin
                        alu_a      <= cmd_a;
                        alu_b      <= cmd_b;
                        alu_select <= cmd_op;
                        r_div0     <= is_div0(cmd_op, cmd_b);
                        cmd_ready  <= 1'b0;
                        r_state    <= ST_EXEC;
                    end
                end
                ST_EXEC: begin
                    // div0 moves to the port here so all rsp_* fields change together
                    rsp_out   <= alu_out;
                    rsp_flags <= {alu_zero, alu_carry, alu_sign, alu_parity};
                    rsp_div0  <= r_div0;
                    rsp_valid <= 1'b1;
                    r_state   <= ST_RESP;
                end
                ST_RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        cmd_ready <= 1'b1;
                        r_state   <= ST_IDLE;
                    end
                end
                default: begin
                    rsp_valid <= 1'b0;
                    cmd_ready <= 1'b1;
                    r_state   <= ST_IDLE;
                end
            endcase
        end
    end

`ifdef ALU_SEQ_STATS_EN
    logic w_rsp_hs;
    assign w_rsp_hs = rsp_valid & rsp_ready;

    alu_seq_stats u_stats (
        .clk          (clk),
        .rst_n        (rst_n),
        .i_hs         (w_rsp_hs),
        .i_carry      (rsp_flags[FLAG_CARRY]),
        .o_stat_ops   (stat_ops),
        .o_stat_carry (stat_carry)
    );
`else
    assign stat_ops   = 8'd0;
    assign stat_carry = 8'd0;
`endif

endmodule

// File: tb/tb_alu_seq_ctrl.sv
// Self-checking bench for alu_seq_ctrl driving the real alu; table vectors plus corner sequences.
module tb_alu_seq_ctrl;
    import alu_seq_pkg::*;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       cmd_valid = 1'b0, cmd_ready;
    logic [3:0] cmd_a = 4'd0, cmd_b = 4'd0;
    logic [1:0] cmd_op = 2'd0;
    logic [3:0] alu_a, alu_b, alu_out;
    logic [1:0] alu_select;
    logic       alu_zero, alu_carry, alu_sign, alu_parity;
    logic       rsp_valid, rsp_ready = 1'b1;
    logic [3:0] rsp_out, rsp_flags;
    logic       rsp_div0;
    logic [7:0] stat_ops, stat_carry;

    always #5 clk = ~clk;

    alu u_alu (
        .a(alu_a), .b(alu_b), .select(alu_select), .out(alu_out),
        .zero(alu_zero), .carry(alu_carry), .sign(alu_sign), .parity(alu_parity)
    );

    alu_seq_ctrl dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_op(cmd_op),
        .alu_a(alu_a), .alu_b(alu_b), .alu_select(alu_select),
        .alu_out(alu_out), .alu_zero(alu_zero), .alu_carry(alu_carry),
        .alu_sign(alu_sign), .alu_parity(alu_parity),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_out(rsp_out), .rsp_flags(rsp_flags), .rsp_div0(rsp_div0),
        .stat_ops(stat_ops), .stat_carry(stat_carry)
    );

    typedef struct {
        logic [3:0] a;
        logic [3:0] b;
        logic [1:0] op;
        logic [3:0] out;
        logic [3:0] flags;
        logic       div0;
    } vec_t;

    typedef struct {
        logic [3:0] out;
        logic [3:0] flags;
        logic       div0;
    } exp_t;

    exp_t  sb[$];
    vec_t  tbl[10];
    int    checks = 0;
    int    errors = 0;
    int    hs_cnt = 0;

    always @(posedge clk)
        if (rst_n && rsp_valid && rsp_ready) hs_cnt <= hs_cnt + 1;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic pop_check(input string tag);
        exp_t e;
        if (sb.size() == 0) begin
            check({tag, "_sb_nonempty"}, 32'd0, 32'd1);
        end else begin
            e = sb.pop_front();
            check({tag, "_rsp_out"},   {28'd0, rsp_out},   {28'd0, e.out});
            check({tag, "_rsp_flags"}, {28'd0, rsp_flags}, {28'd0, e.flags});
            check({tag, "_rsp_div0"},  {31'd0, rsp_div0},  {31'd0, e.div0});
        end
    endtask

    // Called at a negedge with the DUT idle and rsp_ready = 1.
    task automatic do_cmd(input string tag, input logic [3:0] a, input logic [3:0] b,
                          input logic [1:0] op, input logic [3:0] eo, input logic [3:0] ef,
                          input logic ed);
        int lat;
        cmd_a = a; cmd_b = b; cmd_op = op; cmd_valid = 1'b1;
        check({tag, "_cmd_ready"}, {31'd0, cmd_ready}, 32'd1);
        @(posedge clk);
        sb.push_back('{eo, ef, ed});
        @(negedge clk);
        cmd_valid = 1'b0;
        check({tag, "_alu_ops"}, {22'd0, alu_a, alu_b, alu_select}, {22'd0, a, b, op});
        lat = 1;
        while (!rsp_valid && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        check({tag, "_latency"}, lat, 32'd2);
        if (rsp_valid) begin
            pop_check(tag);
            @(negedge clk);
            check({tag, "_back_idle"}, {30'd0, rsp_valid, cmd_ready}, 32'd1);
        end
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int hs0;
        int lat;
        logic [7:0] exp_ops, exp_carry;

        tbl[0] = '{4'd9,  4'd8, OP_ADD, 4'b0001, 4'b0100, 1'b0};
        tbl[1] = '{4'd3,  4'd5, OP_SUB, 4'b1110, 4'b0110, 1'b0};
        tbl[2] = '{4'd7,  4'd0, OP_DIV, 4'b0000, 4'b1001, 1'b1};
        tbl[3] = '{4'd7,  4'd2, OP_DIV, 4'b0011, 4'b0001, 1'b0};
        tbl[4] = '{4'd3,  4'd5, OP_MUL, 4'b1111, 4'b0011, 1'b0};
        tbl[5] = '{4'd5,  4'd4, OP_MUL, 4'b0100, 4'b0100, 1'b0};
        tbl[6] = '{4'd8,  4'd8, OP_SUB, 4'b0000, 4'b1001, 1'b0};
        tbl[7] = '{4'd0,  4'd0, OP_DIV, 4'b0000, 4'b1001, 1'b1};
        tbl[8] = '{4'd15, 4'd1, OP_ADD, 4'b0000, 4'b1101, 1'b0};
        tbl[9] = '{4'd12, 4'd5, OP_DIV, 4'b0010, 4'b0000, 1'b0};

        // Reset with cmd_valid asserted: must not be accepted.
        cmd_valid = 1'b1; cmd_a = 4'd9; cmd_b = 4'd9; cmd_op = OP_MUL;
        repeat (3) @(negedge clk);
        check("rst_cmd_ready", {31'd0, cmd_ready}, 32'd1);
        check("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        check("rst_alu", {22'd0, alu_a, alu_b, alu_select}, 32'd0);
        check("rst_rsp", {23'd0, rsp_out, rsp_flags, rsp_div0}, 32'd0);
        check("rst_stats", {16'd0, stat_ops, stat_carry}, 32'd0);
        cmd_valid = 1'b0;
        rst_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 10; i++)
            do_cmd($sformatf("vec%0d", i), tbl[i].a, tbl[i].b, tbl[i].op,
                   tbl[i].out, tbl[i].flags, tbl[i].div0);

`ifdef ALU_SEQ_STATS_EN
        exp_ops = 8'd10; exp_carry = 8'd4;
`else
        exp_ops = 8'd0;  exp_carry = 8'd0;
`endif
        check("stat_ops_tbl", {24'd0, stat_ops}, {24'd0, exp_ops});
        check("stat_carry_tbl", {24'd0, stat_carry}, {24'd0, exp_carry});

        // Backpressure: response held 5 cycles while another command waits.
        hs0 = hs_cnt;
        rsp_ready = 1'b0;
        cmd_a = 4'd9; cmd_b = 4'd8; cmd_op = OP_ADD; cmd_valid = 1'b1;
        @(posedge clk);
        sb.push_back('{4'b0001, 4'b0100, 1'b0});
        @(negedge clk);
        cmd_a = 4'd15; cmd_b = 4'd1; cmd_op = OP_SUB;
        lat = 1;
        while (!rsp_valid && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        check("bp_latency", lat, 32'd2);
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            check("bp_hold_rsp", {23'd0, rsp_valid, rsp_out, rsp_flags}, {23'd0, 1'b1, 4'b0001, 4'b0100});
            check("bp_cmd_ready", {31'd0, cmd_ready}, 32'd0);
            check("bp_alu_hold", {22'd0, alu_a, alu_b, alu_select}, {22'd0, 4'd9, 4'd8, OP_ADD});
        end
        rsp_ready = 1'b1;
        pop_check("bp");
        @(negedge clk);
        cmd_valid = 1'b0;
        check("bp_idle", {30'd0, rsp_valid, cmd_ready}, 32'd1);
        @(negedge clk);
        check("bp_one_hs", hs_cnt - hs0, 32'd1);
        check("bp_no_new_cmd", {22'd0, alu_a, alu_b, alu_select}, {22'd0, 4'd9, 4'd8, OP_ADD});

        // Reset while in EXEC: command dropped, nothing emitted.
        hs0 = hs_cnt;
        cmd_a = 4'd6; cmd_b = 4'd7; cmd_op = OP_ADD; cmd_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        cmd_a = 4'd5;
        @(negedge clk);
        check("rexec_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        check("rexec_cmd_ready", {31'd0, cmd_ready}, 32'd1);
        check("rexec_alu", {22'd0, alu_a, alu_b, alu_select}, 32'd0);
        check("rexec_stats", {16'd0, stat_ops, stat_carry}, 32'd0);
        @(negedge clk);
        check("rexec_no_accept", {22'd0, alu_a, alu_b, alu_select}, 32'd0);
        rst_n = 1'b1;
        cmd_valid = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            check("rexec_quiet", {31'd0, rsp_valid}, 32'd0);
        end
        check("rexec_no_hs", hs_cnt - hs0, 32'd0);

        // Saturation run.
        for (int i = 0; i < 300; i++)
            do_cmd("sat", 4'd15, 4'd1, OP_ADD, 4'b0000, 4'b1101, 1'b0);
`ifdef ALU_SEQ_STATS_EN
        exp_ops = 8'd255; exp_carry = 8'd255;
`else
        exp_ops = 8'd0;   exp_carry = 8'd0;
`endif
        check("stat_ops_sat", {24'd0, stat_ops}, {24'd0, exp_ops});
        check("stat_carry_sat", {24'd0, stat_carry}, {24'd0, exp_carry});
        check("sb_drained", sb.size(), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
